// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
//   XLEN_DEFAULT : default address width
//   PC_INC       : sequential fetch increment in bytes
//   pc_sel_e     : next-PC source, listed from highest to lowest priority
package pc_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned PC_INC       = 4;

    typedef enum logic [2:0] {
        SEL_RESET    = 3'd0,
        SEL_TRAP     = 3'd1,
        SEL_REDIRECT = 3'd2,
        SEL_RAS      = 3'd3,
        SEL_HOLD     = 3'd4,
        SEL_SEQ      = 3'd5
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
// When full, a push overwrites the oldest entry and the occupancy count
// stays at DEPTH. A push and a pop in the same cycle replace the top entry
// and leave occupancy unchanged. Flush empties the stack in one cycle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : discard all entries
//   push       : write push_data as the new top
//   pop        : remove the top entry (caller guarantees non-empty)
//   push_data  : return address to store
//   top        : current top-of-stack entry
//   empty      : registered, high when occupancy is zero
// DEPTH must lie in 2..16.
module pc_ras #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    // Pointer neighbours with explicit wrap, so non-power-of-two depths work.
    always_comb begin
        ptr_inc = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        ptr_dec = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - PTR_W'(1);
    end

    // Next pointer, occupancy and write port.
    always_comb begin
        ptr_next = ptr;
        cnt_next = cnt;
        wr_en    = 1'b0;
        wr_idx   = ptr;
        if (flush) begin
            cnt_next = '0;
        end else if (push && pop) begin
            wr_en  = 1'b1;
            wr_idx = ptr;
        end else if (push) begin
            wr_en    = 1'b1;
            wr_idx   = ptr_inc;
            ptr_next = ptr_inc;
            if (cnt != CNT_W'(DEPTH)) begin
                cnt_next = cnt + CNT_W'(1);
            end
        end else if (pop) begin
            if (cnt != '0) begin
                ptr_next = ptr_dec;
                cnt_next = cnt - CNT_W'(1);
            end
        end
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            cnt   <= '0;
            empty <= 1'b1;
        end else begin
            ptr   <= ptr_next;
            cnt   <= cnt_next;
            empty <= (cnt_next == '0);
        end
    end

    // Entry storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_data;
        end
    end

    assign top = mem[ptr];

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: selects and registers the next fetch address.
// Priority: reset > trap > redirect > RAS pop > stall (hold) > PC + 4.
// Build macro PC_RAS_EN adds the return-address stack; without it call and
// ret are ignored and ras_empty is held high.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   stall           : hold the PC
//   trap_valid      : load TRAP_VECTOR, flush the RAS
//   redirect_valid  : load redirect_addr with bits [1:0] cleared
//   redirect_addr   : branch/jump target
//   call, ret       : current instruction is a call / return
//   pc_addr         : registered fetch address
//   misalign_err    : one-cycle pulse after an accepted unaligned redirect
//   ras_empty       : RAS holds no entries
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc_addr,
    output logic            misalign_err,
    output logic            ras_empty
);

    pc_sel_e         sel;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] redirect_aligned;
    logic [XLEN-1:0] next_pc;
    logic            misalign_next;
    logic            ras_pop;
    logic            ras_push;
    logic [XLEN-1:0] ras_top;

    assign pc_seq           = pc_addr + XLEN'(PC_INC);
    assign redirect_aligned = {redirect_addr[XLEN-1:2], 2'b00};

`ifdef PC_RAS_EN
    // A pop needs a free-flowing, non-overridden return with a live entry;
    // a push only needs the call to retire (a jump-and-link also redirects).
    assign ras_pop  = ret && !stall && !trap_valid && !redirect_valid && !ras_empty;
    assign ras_push = call && !stall && !trap_valid;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .flush     (trap_valid),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_ras_inputs;

    assign ras_pop           = 1'b0;
    assign ras_push          = 1'b0;
    assign ras_top           = '0;
    assign ras_empty         = 1'b1;
    assign unused_ras_inputs = ^{call, ret, ras_push};
`endif

    // Next-PC source selection.
    always_comb begin
        sel = SEL_SEQ;
        if (rst) begin
            sel = SEL_RESET;
        end else if (trap_valid) begin
            sel = SEL_TRAP;
        end else if (redirect_valid) begin
            sel = SEL_REDIRECT;
`ifdef PC_RAS_EN
        end else if (ras_pop) begin
            sel = SEL_RAS;
`endif
        end else if (stall) begin
            sel = SEL_HOLD;
        end
    end

    // Next-PC mux.
    always_comb begin
        next_pc = pc_seq;
        unique case (sel)
            SEL_RESET:    next_pc = RESET_VECTOR;
            SEL_TRAP:     next_pc = TRAP_VECTOR;
            SEL_REDIRECT: next_pc = redirect_aligned;
            SEL_RAS:      next_pc = ras_top;
            SEL_HOLD:     next_pc = pc_addr;
            SEL_SEQ:      next_pc = pc_seq;
        endcase
    end

    // A trap swallows the redirect, and its alignment error with it.
    assign misalign_next = redirect_valid && !trap_valid && (redirect_addr[1:0] != 2'b00);

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_addr      <= RESET_VECTOR;
            misalign_err <= 1'b0;
        end else begin
            pc_addr      <= next_pc;
            misalign_err <= misalign_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed sequence plus a random phase,
// with expected values from a reference model pushed into a scoreboard.
module tb_pc_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] TV    = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic        mis;
        logic        emp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        trap_valid;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        call;
    logic        ret;
    logic [31:0] pc_addr;
    logic        misalign_err;
    logic        ras_empty;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .trap_valid     (trap_valid),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .call           (call),
        .ret            (ret),
        .pc_addr        (pc_addr),
        .misalign_err   (misalign_err),
        .ras_empty      (ras_empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: stack kept as a queue, newest at the back.
    task automatic model(input logic r, input logic s, input logic t, input logic rv,
                         input logic [31:0] ra, input logic c, input logic rt);
        exp_t        e;
        logic [31:0] npc;
        logic [31:0] link;
        logic        pop;
        logic        push;
        logic        mis;
        link = m_pc + 32'd4;
        mis  = 1'b0;
        pop  = 1'b0;
        push = 1'b0;
        if (r) begin
            m_pc = RV;
            m_ras.delete();
        end else if (t) begin
            m_pc = TV;
            m_ras.delete();
        end else begin
`ifdef PC_RAS_EN
            pop  = rt && !s && !rv && (m_ras.size() > 0);
            push = c && !s;
`endif
            if (rv)        npc = {ra[31:2], 2'b00};
            else if (pop)  npc = m_ras[m_ras.size() - 1];
            else if (s)    npc = m_pc;
            else           npc = link;
            mis = rv && (ra[1:0] != 2'b00);
            if (pop && push) begin
                m_ras[m_ras.size() - 1] = link;
            end else if (pop) begin
                void'(m_ras.pop_back());
            end else if (push) begin
                m_ras.push_back(link);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_pc = npc;
        end
        e.pc  = m_pc;
        e.mis = mis;
        e.emp = (m_ras.size() == 0);
        sb.push_back(e);
    endtask

    // One clock: drive on the falling edge, compare 1 time unit after the rising edge.
    task automatic step(input string tag, input logic r, input logic s, input logic t,
                        input logic rv, input logic [31:0] ra, input logic c, input logic rt);
        exp_t e;
        @(negedge clk);
        rst            = r;
        stall          = s;
        trap_valid     = t;
        redirect_valid = rv;
        redirect_addr  = ra;
        call           = c;
        ret            = rt;
        model(r, s, t, rv, ra, c, rt);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_pc"},  pc_addr,             e.pc);
            check({tag, "_mis"}, 32'(misalign_err),   32'(e.mis));
            check({tag, "_emp"}, 32'(ras_empty),      32'(e.emp));
        end
    endtask

    task automatic free(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic redir(input string tag, input logic [31:0] a, input logic c);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b1, a, c, 1'b0);
    endtask

    task automatic do_ret(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; trap_valid = 1'b0; redirect_valid = 1'b0;
        redirect_addr = '0; call = 1'b0; ret = 1'b0;
        m_pc = RV;

        // Reset state
        step("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("rst_pc", pc_addr, 32'h0);
        check("rst_mis", 32'(misalign_err), 32'h0);
        check("rst_emp", 32'(ras_empty), 32'h1);

        // Free run after reset release
        free("seq1"); check("seq_4", pc_addr, 32'h4);
        free("seq2"); check("seq_8", pc_addr, 32'h8);
        free("seq3"); check("seq_c", pc_addr, 32'hC);
        free("seq4"); check("seq_10", pc_addr, 32'h10);

        // Redirect overrides stall, then stall holds
        step("rst2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        free("s1"); free("s2");
        check("at_8", pc_addr, 32'h8);
        step("stall_redir", 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0);
        check("stall_redir_20", pc_addr, 32'h20);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            check("hold_20", pc_addr, 32'h20);
        end

        // Misaligned redirect, then same with trap
        redir("mis_redir", 32'h43, 1'b0);
        check("mis_pc_40", pc_addr, 32'h40);
        check("mis_pulse", 32'(misalign_err), 32'h1);
        free("mis_after");
        check("mis_drop", 32'(misalign_err), 32'h0);
        step("mis_trap", 1'b0, 1'b0, 1'b1, 1'b1, 32'h43, 1'b0, 1'b0);
        check("trap_pc", pc_addr, 32'h100);
        check("trap_nomis", 32'(misalign_err), 32'h0);

`ifdef PC_RAS_EN
        // Call/return
        redir("to_10", 32'h10, 1'b0);
        redir("jal_200", 32'h200, 1'b1);
        check("jal_nonempty", 32'(ras_empty), 32'h0);
        free("f204"); free("f208");
        do_ret("ret1"); check("ret_14", pc_addr, 32'h14);
        redir("to_208", 32'h208, 1'b0);
        do_ret("ret_empty"); check("ret_seq_20c", pc_addr, 32'h20C);
        check("ret_empty_flag", 32'(ras_empty), 32'h1);

        // Five nested calls into a four-entry stack
        redir("to_1000", 32'h1000, 1'b0);
        for (int i = 2; i <= 6; i++) redir("nest", 32'(i) << 12, 1'b1);
        do_ret("nret1"); check("nret_5004", pc_addr, 32'h5004);
        do_ret("nret2"); check("nret_4004", pc_addr, 32'h4004);
        do_ret("nret3"); check("nret_3004", pc_addr, 32'h3004);
        do_ret("nret4"); check("nret_2004", pc_addr, 32'h2004);
        do_ret("nret5"); check("nret_seq", pc_addr, 32'h2008);

        // Trap flushes the stack
        redir("c7", 32'h7000, 1'b1);
        redir("c8", 32'h8000, 1'b1);
        step("trap_flush", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        check("flush_emp", 32'(ras_empty), 32'h1);
        do_ret("ret_after_flush"); check("flush_seq", pc_addr, 32'h104);

        // Simultaneous push and pop
        redir("c9", 32'h9000, 1'b1);
        step("pushpop", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("pushpop_pc", pc_addr, 32'h108);
        do_ret("pp_ret"); check("pp_ret_pc", pc_addr, 32'h9004);
`endif

        // Wrap at the top of the address space, then mid-run reset
        redir("to_top", 32'hFFFF_FFFC, 1'b0);
        free("wrap"); check("wrap_0", pc_addr, 32'h0);
        step("call0", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step("midrst", 1'b1, 1'b0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1);
        check("midrst_pc", pc_addr, RV);
        check("midrst_emp", 32'(ras_empty), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) == 0),
                 $urandom,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
